led_mode_ctrl: RTL

Mode controller for the 8-LED bank driven by the 4 slide switches. Debounces the switches and a mode pushbutton, then schedules one of four display modes onto the LEDs: static mirror, chase, bounce and blink. It sits between the raw board inputs and the LED pins, and replaces direct switch-to-LED wiring at the top level.

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/input_debounce.sv | 48 ++++
 rtl/led_mode_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encodings, LED width and mirror mapping for the LED mode controller
package led_ctrl_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Each switch lights a symmetric pair of LEDs: bit i and bit 7-i.
  function automatic logic [LED_W-1:0] mirror_pattern(input logic [3:0] sw);
    logic [LED_W-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i]           = sw[i];
      m[LED_W-1-i]   = sw[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - per-bit 2-FF synchronizer followed by a stable-count debouncer
module input_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [CW-1:0] cnt;

    // The last counted mismatch cycle commits the new value, so a change
    // is accepted on exactly the DEBOUNCE_CYCLES-th differing edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        dout[b] <= 1'b0;
      end else if (sync2[b] == dout[b]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        dout[b] <= sync2[b];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - debounced switch/button inputs scheduled onto the LED bank in four display modes
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       SlideSwitch,
  input  logic             BtnMode,
  output logic [LED_W-1:0] LEDOut,
  output logic [1:0]       Mode
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [3:0]       sw_db;
  logic             btn_db;
  logic             btn_prev;
  logic             btn_rise;
  logic             tick;

  mode_e            mode_q, mode_n;
  logic [2:0]       pos_q, pos_n;
  logic             dir_q, dir_n;
  logic             phase_q, phase_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic [LED_W-1:0] mirror_m;
  logic [LED_W-1:0] led_n;

  input_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SlideSwitch),
    .dout  (sw_db)
  );

  input_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (BtnMode),
    .dout  (btn_db)
  );

  assign btn_rise = btn_db & ~btn_prev;
  assign tick     = (presc_q == PRESC_LAST);
  assign mirror_m = mirror_pattern(sw_db);

  // A button edge outranks a coincident tick: the new mode starts from its entry state.
  always_comb begin
    mode_n  = mode_q;
    pos_n   = pos_q;
    dir_n   = dir_q;
    phase_n = phase_q;
    presc_n = tick ? '0 : presc_q + PW'(1);
    if (btn_rise) begin
      case (mode_q)
        MODE_MIRROR: mode_n = MODE_CHASE;
        MODE_CHASE:  mode_n = MODE_BOUNCE;
        MODE_BOUNCE: mode_n = MODE_BLINK;
        default:     mode_n = MODE_MIRROR;
      endcase
      pos_n   = 3'd0;
      dir_n   = DIR_UP;
      phase_n = 1'b1;
      presc_n = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_CHASE: pos_n = pos_q + 3'd1;
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pos_n = pos_q + 3'd1;
            if (pos_q == 3'd6) dir_n = DIR_DOWN;
          end else begin
            pos_n = pos_q - 3'd1;
            if (pos_q == 3'd1) dir_n = DIR_UP;
          end
        end
        MODE_BLINK: phase_n = ~phase_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_n = '0;
    case (mode_n)
      MODE_MIRROR: led_n = mirror_m;
      MODE_CHASE,
      MODE_BOUNCE: led_n = LED_W'(1) << pos_n;
      default:     led_n = phase_n ? mirror_m : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_MIRROR;
      pos_q    <= 3'd0;
      dir_q    <= DIR_UP;
      phase_q  <= 1'b1;
      presc_q  <= '0;
      btn_prev <= 1'b0;
      LEDOut   <= '0;
    end else begin
      mode_q   <= mode_n;
      pos_q    <= pos_n;
      dir_q    <= dir_n;
      phase_q  <= phase_n;
      presc_q  <= presc_n;
      btn_prev <= btn_db;
      LEDOut   <= led_n;
    end
  end

  assign Mode = mode_q;

endmodule
